mem_read_port: RTL and testbench

- Reader side of the memory data path. The datapath registers capture values; this block fetches a word from memory so it can be loaded into the MDR or put on the bus.
- Control unit pulses start with an address (from MAR). Block runs a request/acknowledge read handshake with memory, captures the returned word into a held output register and signals completion.
- Sits between the control unit / MAR and the external memory interface.

---
 rtl/mem_read_port.sv | 119 +++++++++++
 tb/tb_mem_read_port.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_port.sv
// mem_read_port: request/acknowledge memory reader with a held data register.
// Define MEM_READ_TIMEOUT_EN to abort reads that see no ack for TIMEOUT cycles.
module mem_read_port #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] data_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] data_n;
   logic              rd_n;
   logic              busy_n;
   logic              done_n;

`ifdef MEM_READ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt, cnt_n;
   logic          err_n;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT >= 1);
   assign err = 1'b0;
`endif

   always_comb begin
      state_n = state;
      addr_n  = mem_addr;
      data_n  = data_out;
      rd_n    = mem_rd;
      busy_n  = busy;
      done_n  = 1'b0;
`ifdef MEM_READ_TIMEOUT_EN
      cnt_n   = cnt;
      err_n   = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               addr_n  = addr;
               rd_n    = 1'b1;
               busy_n  = 1'b1;
               state_n = REQ;
`ifdef MEM_READ_TIMEOUT_EN
               cnt_n   = '0;
`endif
            end
         end
         REQ: begin
            // an ack in the final counted cycle still wins over timeout
            if (mem_ack) begin
               data_n  = mem_rdata;
               rd_n    = 1'b0;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               state_n = IDLE;
            end
`ifdef MEM_READ_TIMEOUT_EN
            else if (cnt == LAST) begin
               rd_n    = 1'b0;
               busy_n  = 1'b0;
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n   = cnt + CW'(1);
            end
`endif
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         mem_addr <= '0;
         data_out <= '0;
         mem_rd   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         mem_addr <= addr_n;
         data_out <= data_n;
         mem_rd   <= rd_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

`ifdef MEM_READ_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         cnt <= cnt_n;
         err <= err_n;
      end
   end
`endif

endmodule

// File: tb/tb_mem_read_port.sv
// tb_mem_read_port: randomized bench for mem_read_port against a
// transaction-level model and a latency-programmable memory responder.
module tb_mem_read_port;

   localparam int DW = 32;
   localparam int AW = 9;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          busy, done, err, mem_rd;
   logic [DW-1:0] data_out;
   logic [AW-1:0] mem_addr;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_read_port #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .addr(addr),
      .busy(busy), .done(done), .err(err), .data_out(data_out),
      .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   int cmp_n = 0;
   int bad_n = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   logic [31:0] mem [512];

   // Model: one outstanding read at a time, data comes from the word array
   bit          m_pend = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [31:0] m_data = '0;
   bit          m_done = 1'b0;
   bit          m_err = 1'b0;
   int          m_wait = 0;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_pend = 1'b0; m_addr = '0; m_data = '0;
         m_done = 1'b0; m_err = 1'b0; m_wait = 0;
      end else begin
         m_done = 1'b0;
         m_err  = 1'b0;
         if (!m_pend) begin
            if (start) begin
               m_pend = 1'b1;
               m_addr = addr;
               m_wait = 0;
            end
         end else if (mem_ack) begin
            m_pend = 1'b0;
            m_data = mem[int'(m_addr)];
            m_done = 1'b1;
         end else begin
            m_wait++;
`ifdef MEM_READ_TIMEOUT_EN
            if (m_wait == TO) begin
               m_pend = 1'b0;
               m_err  = 1'b1;
            end
`endif
         end
      end
   end

   // Responder: ack during the lat-th cycle of mem_rd (lat 0 = never)
   int hcnt = 0;
   int lat = 3;
   bit rand_lat = 1'b0;
   bit stray = 1'b0;
   bit force_ack = 1'b0;

   initial forever begin
      @(negedge clk);
      #1;
      if (mem_rd) begin
         hcnt++;
         if (hcnt == 1 && rand_lat) begin
`ifdef MEM_READ_TIMEOUT_EN
            lat = $urandom_range(0, 18);
`else
            lat = $urandom_range(1, 6);
`endif
         end
      end else begin
         hcnt = 0;
      end
      if (mem_rd && lat != 0 && hcnt >= lat) begin
         mem_ack   = 1'b1;
         mem_rdata = mem[int'(mem_addr)];
      end else begin
         mem_ack   = force_ack |
                     (stray & !mem_rd & ($urandom_range(0, 1) != 0));
         mem_rdata = $urandom;
      end
   end

   int done_cnt = 0;
   int err_cnt = 0;
   int run = 0;
   int last_run = 0;

   initial forever begin
      @(negedge clk);
      chk("busy", busy, m_pend);
      chk("mem_rd", mem_rd, m_pend);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("mem_addr", mem_addr, m_addr);
      chk("data_out", data_out, m_data);
      done_cnt += int'(done);
      err_cnt  += int'(err);
      if (mem_rd) run++;
      else if (run > 0) begin
         last_run = run;
         run = 0;
      end
   end

   logic [31:0] prev;

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      mem[9'h0A5] = 32'hDEADBEEF;

      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      repeat (5) @(negedge clk);
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rd", mem_rd, 0);
      chk("rst_data", data_out, 32'h0);
      chk("rst_addr", mem_addr, 0);

      // single read, ack in the third strobe cycle
      lat = 3; done_cnt = 0;
      start = 1'b1; addr = 9'h0A5;
      @(negedge clk);
      start = 1'b0; addr = AW'($urandom);
      repeat (8) @(negedge clk);
      #3;
      chk("t1_rd_len", last_run, 3);
      chk("t1_dones", done_cnt, 1);
      chk("t1_data", data_out, 32'hDEADBEEF);
      chk("t1_addr", mem_addr, 9'h0A5);

      // reset in the middle of a read, then a stray ack
      lat = 0; done_cnt = 0;
      start = 1'b1; addr = 9'h12C;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_rd", mem_rd, 0);
      chk("rst_mid_busy", busy, 0);
      force_ack = 1'b1;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      force_ack = 1'b0;
      repeat (2) @(negedge clk);
      #3;
      chk("rst_mid_dones", done_cnt, 0);
      chk("rst_mid_data", data_out, 32'h0);

      // second start while busy is dropped
      lat = 4; done_cnt = 0;
      start = 1'b1; addr = 9'h033;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; addr = 9'h1FF;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #3;
      chk("busy_addr", mem_addr, 9'h033);
      chk("busy_dones", done_cnt, 1);
      chk("busy_data", data_out, mem[9'h033]);

      // zero-wait memory with start held high
      lat = 1; done_cnt = 0;
      start = 1'b1; addr = AW'($urandom);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         addr = AW'($urandom);
      end
      #3;
      start = 1'b0;
      chk("b2b_dones", done_cnt, 10);
      chk("b2b_rd_len", last_run, 1);
      repeat (3) @(negedge clk);

      // randomized traffic
      rand_lat = 1'b1; stray = 1'b1;
      repeat (400) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         addr  = AW'($urandom);
      end
      start = 1'b0; stray = 1'b0;
      repeat (30) @(negedge clk);
      rand_lat = 1'b0;

`ifdef MEM_READ_TIMEOUT_EN
      // no ack: strobe lasts TO cycles, then err
      #3;
      lat = 0; done_cnt = 0; err_cnt = 0; prev = m_data;
      start = 1'b1; addr = 9'h0A5;
      @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
      #3;
      chk("to_rd_len", last_run, TO);
      chk("to_errs", err_cnt, 1);
      chk("to_dones", done_cnt, 0);
      chk("to_data", data_out, prev);
      chk("to_busy", busy, 0);

      // ack in the last allowed cycle wins
      lat = TO; done_cnt = 0; err_cnt = 0;
      start = 1'b1; addr = 9'h0A5;
      @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
      #3;
      chk("late_rd_len", last_run, TO);
      chk("late_dones", done_cnt, 1);
      chk("late_errs", err_cnt, 0);
      chk("late_data", data_out, 32'hDEADBEEF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
      $finish;
   end

endmodule
